lockbox_ct: RTL

//  Multi-slot tagged secret store, successor to the two-slot lockbox. Every operation has fixed,

---
 rtl/lockbox_ct_if.sv | 26 ++
 rtl/lockbox_ct.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lockbox_ct_if.sv
// Request/response bundle between the host command decoder and lockbox_ct.
// The host side is the master; the lockbox is the slave.
interface lockbox_ct_if #(
   parameter int unsigned TAG_WIDTH = 16,
   parameter int unsigned WIDTH     = 128
) ();
   logic                 i_en;
   logic                 i_op;
   logic [TAG_WIDTH-1:0] i_tag;
   logic [WIDTH-1:0]     i_secret;
   logic [WIDTH-1:0]     i_password;
   logic                 o_ready;
   logic [WIDTH-1:0]     o_out;
   logic [1:0]           o_status;
   logic                 o_valid;

   modport master (
      output i_en, i_op, i_tag, i_secret, i_password,
      input  o_ready, o_out, o_status, o_valid
   );

   modport slave (
      input  i_en, i_op, i_tag, i_secret, i_password,
      output o_ready, o_out, o_status, o_valid
   );
endinterface

// File: rtl/lockbox_ct.sv
// Multi-slot tagged secret store with fixed TAGS+1 edge latency for every operation,
// per-slot failed-password counting and lockout erase.
module lockbox_ct #(
   parameter int unsigned TAGS      = 4,
   parameter int unsigned TAG_WIDTH = 16,
   parameter int unsigned WIDTH     = 128,
   parameter int unsigned MAX_FAILS = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   lockbox_ct_if.slave  bus
);
   localparam int unsigned IW = $clog2(TAGS + 1);
   localparam int unsigned AW = $clog2(TAGS);
   localparam int unsigned FW = $clog2(MAX_FAILS + 1);
   localparam logic [IW-1:0] NONE      = IW'(TAGS);
   localparam logic [IW-1:0] LAST      = IW'(TAGS - 1);
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);

   typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

   state_e               state_q;
   logic                 row_valid_q [TAGS];
   logic [TAG_WIDTH-1:0] tag_q       [TAGS];
   logic [WIDTH-1:0]     secret_q    [TAGS];
   logic [WIDTH-1:0]     pw_q        [TAGS];
   logic [FW-1:0]        fail_q      [TAGS];

   logic                 op_q;
   logic [TAG_WIDTH-1:0] req_tag_q;
   logic [WIDTH-1:0]     req_secret_q;
   logic [WIDTH-1:0]     req_pw_q;
   logic [IW-1:0]        idx_q;
   logic [IW-1:0]        hit_q;
   logic [IW-1:0]        free_q;

   logic [WIDTH-1:0]     out_q;
   logic [1:0]           status_q;
   logic                 valid_q;

   // hit_q/free_q are only used as addresses once known to be below TAGS
   logic [AW-1:0] scan_a, hit_a, free_a;
   assign scan_a = idx_q[AW-1:0];
   assign hit_a  = hit_q[AW-1:0];
   assign free_a = free_q[AW-1:0];

   assign bus.o_ready  = (state_q == StIdle) && !valid_q;
   assign bus.o_out    = out_q;
   assign bus.o_status = status_q;
   assign bus.o_valid  = valid_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         op_q         <= 1'b0;
         req_tag_q    <= '0;
         req_secret_q <= '0;
         req_pw_q     <= '0;
         idx_q        <= '0;
         hit_q        <= NONE;
         free_q       <= NONE;
         out_q        <= '0;
         status_q     <= 2'b00;
         valid_q      <= 1'b0;
         for (int i = 0; i < TAGS; i++) begin
            row_valid_q[i] <= 1'b0;
            tag_q[i]       <= '0;
            secret_q[i]    <= '0;
            pw_q[i]        <= '0;
            fail_q[i]      <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_q) begin
                  valid_q  <= 1'b0;
                  out_q    <= '0;
                  status_q <= 2'b00;
               end else if (bus.i_en) begin
                  op_q         <= bus.i_op;
                  req_tag_q    <= bus.i_tag;
                  req_secret_q <= bus.i_secret;
                  req_pw_q     <= bus.i_password;
                  idx_q        <= '0;
                  hit_q        <= NONE;
                  free_q       <= NONE;
                  state_q      <= StScan;
               end
            end
            // Visits every slot regardless of outcome so latency never depends on data
            StScan: begin
               if (row_valid_q[scan_a] && (tag_q[scan_a] == req_tag_q) && (hit_q == NONE))
                  hit_q <= idx_q;
               if (!row_valid_q[scan_a] && (free_q == NONE))
                  free_q <= idx_q;
               idx_q <= idx_q + 1'b1;
               if (idx_q == LAST) state_q <= StCommit;
            end
            StCommit: begin
               valid_q <= 1'b1;
               state_q <= StIdle;
               out_q   <= '0;
               if (!op_q) begin
                  if (hit_q == NONE) begin
                     status_q <= 2'b01;
                  end else if (pw_q[hit_a] == req_pw_q) begin
                     out_q               <= secret_q[hit_a];
                     status_q            <= 2'b00;
                     row_valid_q[hit_a]  <= 1'b0;
                     tag_q[hit_a]        <= '0;
                     secret_q[hit_a]     <= '0;
                     pw_q[hit_a]         <= '0;
                     fail_q[hit_a]       <= '0;
                  end else if (fail_q[hit_a] >= FAIL_LAST) begin
                     status_q            <= 2'b11;
                     row_valid_q[hit_a]  <= 1'b0;
                     tag_q[hit_a]        <= '0;
                     secret_q[hit_a]     <= '0;
                     pw_q[hit_a]         <= '0;
                     fail_q[hit_a]       <= '0;
                  end else begin
                     status_q      <= 2'b01;
                     fail_q[hit_a] <= fail_q[hit_a] + 1'b1;
                  end
               end else begin
                  if (hit_q != NONE) begin
                     out_q           <= WIDTH'(1);
                     status_q        <= 2'b00;
                     secret_q[hit_a] <= req_secret_q;
                     pw_q[hit_a]     <= req_pw_q;
                     fail_q[hit_a]   <= '0;
                  end else if (free_q != NONE) begin
                     out_q               <= WIDTH'(1);
                     status_q            <= 2'b00;
                     row_valid_q[free_a] <= 1'b1;
                     tag_q[free_a]       <= req_tag_q;
                     secret_q[free_a]    <= req_secret_q;
                     pw_q[free_a]        <= req_pw_q;
                     fail_q[free_a]      <= '0;
                  end else begin
                     status_q <= 2'b10;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule
